// File: rtl/instr_pipe_chain.sv
// instr_pipe_chain: DEPTH-deep instruction/PC pipeline with per-stage valid bits.
// An empty stage always accepts an entry, so bubbles close up even while the
// output is stalled. FLUSH clears every valid bit and drops the input entry.
// OCCUPANCY is a registered count of the valid stages.
module instr_pipe_chain #(
    parameter int INSTR_W = 11,
    parameter int PC_W    = 6,
    parameter int DEPTH   = 3,
    parameter int OCC_W   = $clog2(DEPTH + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               VALID_IN,
    input  logic [INSTR_W-1:0] INSTR_IN,
    input  logic [PC_W-1:0]    COUNTER_IN,
    output logic               IN_READY,
    input  logic               STALL,
    input  logic               FLUSH,
    output logic               VALID_OUT,
    output logic [INSTR_W-1:0] INSTR_OUT,
    output logic [PC_W-1:0]    COUNTER_OUT,
    output logic [DEPTH-1:0]   STAGE_VALID,
    output logic [OCC_W-1:0]   OCCUPANCY
);

    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   valid_d;
    logic [DEPTH:0]     ready;
    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [PC_W-1:0]    pc_q    [DEPTH];
    logic [OCC_W-1:0]   occ_q;
    logic [OCC_W-1:0]   occ_d;

    // Build the ready chain from the output back to the input.
    // A stage is ready when it is empty or when the stage ahead of it is ready.
    always_comb begin
        ready[DEPTH] = !STALL;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            ready[k] = !valid_q[k] || ready[k+1];
        end
    end

    // Next-state valid bits. A ready stage takes the valid bit of its source.
    // FLUSH clears every stage, and the input entry is lost with them.
    always_comb begin
        valid_d = valid_q;
        if (FLUSH) begin
            valid_d = '0;
        end else begin
            if (ready[0]) begin
                valid_d[0] = VALID_IN;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (ready[k]) begin
                    valid_d[k] = valid_q[k-1];
                end
            end
        end
    end

    // Occupancy is the popcount of the next-state valid bits.
    always_comb begin
        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + OCC_W'(valid_d[k]);
        end
    end

    // Stage registers. A data field loads only when its source holds a valid
    // entry; otherwise the field keeps its old value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                instr_q[k] <= '0;
                pc_q[k]    <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            if (!FLUSH) begin
                if (ready[0] && VALID_IN) begin
                    instr_q[0] <= INSTR_IN;
                    pc_q[0]    <= COUNTER_IN;
                end
                for (int k = 1; k < DEPTH; k++) begin
                    if (ready[k] && valid_q[k-1]) begin
                        instr_q[k] <= instr_q[k-1];
                        pc_q[k]    <= pc_q[k-1];
                    end
                end
            end
        end
    end

    assign IN_READY    = ready[0];
    assign VALID_OUT   = valid_q[DEPTH-1];
    assign INSTR_OUT   = instr_q[DEPTH-1];
    assign COUNTER_OUT = pc_q[DEPTH-1];
    assign STAGE_VALID = valid_q;
    assign OCCUPANCY   = occ_q;

endmodule

// File: tb/tb_instr_pipe_chain.sv
// Bench for instr_pipe_chain: directed scenarios and a randomized run on the
// default DEPTH=3 instance, plus a latency and saturation sweep on DEPTH=1 and
// DEPTH=5 instances.
module tb_instr_pipe_chain;

    localparam int D = 3;

    logic        CLK;
    logic        RST;
    logic        VALID_IN;
    logic [10:0] INSTR_IN;
    logic [5:0]  COUNTER_IN;
    logic        IN_READY;
    logic        STALL;
    logic        FLUSH;
    logic        VALID_OUT;
    logic [10:0] INSTR_OUT;
    logic [5:0]  COUNTER_OUT;
    logic [2:0]  STAGE_VALID;
    logic [1:0]  OCCUPANCY;

    logic        s_rst, s_vin, s_stall, s_flush;
    logic [31:0] s_instr;
    logic [15:0] s_pc;
    logic        o1_ready, o1_valid;
    logic [31:0] o1_instr;
    logic [15:0] o1_pc;
    logic [0:0]  o1_sv;
    logic [0:0]  o1_occ;
    logic        o5_ready, o5_valid;
    logic [31:0] o5_instr;
    logic [15:0] o5_pc;
    logic [4:0]  o5_sv;
    logic [2:0]  o5_occ;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one slot per stage, front slot (index D-1) is the output.
    logic [D-1:0] m_v;
    logic [10:0]  m_i [D];
    logic [5:0]   m_p [D];

    instr_pipe_chain dut (
        .CLK(CLK), .RST(RST), .VALID_IN(VALID_IN), .INSTR_IN(INSTR_IN),
        .COUNTER_IN(COUNTER_IN), .IN_READY(IN_READY), .STALL(STALL), .FLUSH(FLUSH),
        .VALID_OUT(VALID_OUT), .INSTR_OUT(INSTR_OUT), .COUNTER_OUT(COUNTER_OUT),
        .STAGE_VALID(STAGE_VALID), .OCCUPANCY(OCCUPANCY)
    );

    instr_pipe_chain #(.INSTR_W(32), .PC_W(16), .DEPTH(1)) dut1 (
        .CLK(CLK), .RST(s_rst), .VALID_IN(s_vin), .INSTR_IN(s_instr),
        .COUNTER_IN(s_pc), .IN_READY(o1_ready), .STALL(s_stall), .FLUSH(s_flush),
        .VALID_OUT(o1_valid), .INSTR_OUT(o1_instr), .COUNTER_OUT(o1_pc),
        .STAGE_VALID(o1_sv), .OCCUPANCY(o1_occ)
    );

    instr_pipe_chain #(.INSTR_W(32), .PC_W(16), .DEPTH(5)) dut5 (
        .CLK(CLK), .RST(s_rst), .VALID_IN(s_vin), .INSTR_IN(s_instr),
        .COUNTER_IN(s_pc), .IN_READY(o5_ready), .STALL(s_stall), .FLUSH(s_flush),
        .VALID_OUT(o5_valid), .INSTR_OUT(o5_instr), .COUNTER_OUT(o5_pc),
        .STAGE_VALID(o5_sv), .OCCUPANCY(o5_occ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // The pipe refuses input only when every slot is full and the output is stalled.
    function automatic logic model_ready();
        return !((&m_v) && STALL);
    endfunction

    // Advance the model by one edge using the inputs currently applied.
    // When stalled, the packed run of entries at the output stays put. Every
    // slot behind that run moves one place forward into the gap.
    task automatic model_edge();
        int h;
        if (RST) begin
            m_v = '0;
            for (int k = 0; k < D; k++) begin
                m_i[k] = '0;
                m_p[k] = '0;
            end
        end else if (FLUSH) begin
            m_v = '0;
        end else begin
            h = D;
            if (STALL) begin
                while (h > 0 && m_v[h-1]) h--;
            end
            for (int k = h - 1; k >= 1; k--) begin
                if (m_v[k-1]) begin
                    m_i[k] = m_i[k-1];
                    m_p[k] = m_p[k-1];
                end
                m_v[k] = m_v[k-1];
            end
            if (h > 0) begin
                if (VALID_IN) begin
                    m_i[0] = INSTR_IN;
                    m_p[0] = COUNTER_IN;
                end
                m_v[0] = VALID_IN;
            end
        end
    endtask

    task automatic apply(input logic vin, input logic [10:0] ins, input logic [5:0] pc,
                         input logic st, input logic fl, input logic rs);
        VALID_IN = vin; INSTR_IN = ins; COUNTER_IN = pc;
        STALL = st; FLUSH = fl; RST = rs;
        #1;
    endtask

    task automatic apply_s(input logic vin, input logic [31:0] ins, input logic [15:0] pc,
                           input logic st, input logic fl, input logic rs);
        s_vin = vin; s_instr = ins; s_pc = pc;
        s_stall = st; s_flush = fl; s_rst = rs;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        apply(1'b1, 11'h555, 6'h2A, 1'b1, 1'b1, 1'b1);
        model_edge();
        tick();
        n_vec++;
        if (VALID_OUT !== 1'b0 || INSTR_OUT !== 11'h0 || COUNTER_OUT !== 6'h0) begin
            n_err++;
            $display("FAIL reset_out: got v=%0b i=%h pc=%h want 0/000/00", VALID_OUT, INSTR_OUT, COUNTER_OUT);
        end
        n_vec++;
        if (STAGE_VALID !== 3'b000 || OCCUPANCY !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state: got sv=%b occ=%0d want 000/0", STAGE_VALID, OCCUPANCY);
        end
        apply(1'b0, 11'h0, 6'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 1", IN_READY);
        end
    endtask

    task automatic test_stream();
        logic [10:0] ins_t [3];
        int occ_t [6];
        ins_t[0] = 11'h7FF; ins_t[1] = 11'h000; ins_t[2] = 11'h6B5;
        occ_t[0] = 1; occ_t[1] = 2; occ_t[2] = 3; occ_t[3] = 2; occ_t[4] = 1; occ_t[5] = 0;
        for (int c = 0; c < 6; c++) begin
            if (c < 3) apply(1'b1, ins_t[c], 6'(c + 1), 1'b0, 1'b0, 1'b0);
            else       apply(1'b0, 11'h0, 6'h0, 1'b0, 1'b0, 1'b0);
            model_edge();
            tick();
            n_vec++;
            if (OCCUPANCY !== 2'(occ_t[c])) begin
                n_err++;
                $display("FAIL stream_occ[%0d]: got %0d want %0d", c, OCCUPANCY, occ_t[c]);
            end
            if (c >= 2 && c <= 4) begin
                n_vec++;
                if (VALID_OUT !== 1'b1 || INSTR_OUT !== ins_t[c-2] || COUNTER_OUT !== 6'(c - 1)) begin
                    n_err++;
                    $display("FAIL stream_out[%0d]: got v=%b %h/%0d want 1 %h/%0d",
                             c, VALID_OUT, INSTR_OUT, COUNTER_OUT, ins_t[c-2], c - 1);
                end
            end
        end
    endtask

    task automatic test_bubble();
        logic        v_t [6];
        logic [10:0] i_t [6];
        logic [5:0]  p_t [6];
        logic        s_t [6];
        logic [2:0]  sv_t [6];
        v_t[0]=1; i_t[0]=11'h7FF; p_t[0]=6'd1; s_t[0]=0; sv_t[0]=3'b001;
        v_t[1]=0; i_t[1]=11'h000; p_t[1]=6'd0; s_t[1]=0; sv_t[1]=3'b010;
        v_t[2]=0; i_t[2]=11'h000; p_t[2]=6'd0; s_t[2]=0; sv_t[2]=3'b100;
        v_t[3]=1; i_t[3]=11'h6B5; p_t[3]=6'd3; s_t[3]=1; sv_t[3]=3'b101;
        v_t[4]=0; i_t[4]=11'h000; p_t[4]=6'd0; s_t[4]=1; sv_t[4]=3'b110;
        v_t[5]=1; i_t[5]=11'h0AA; p_t[5]=6'd4; s_t[5]=1; sv_t[5]=3'b111;
        for (int c = 0; c < 6; c++) begin
            apply(v_t[c], i_t[c], p_t[c], s_t[c], 1'b0, 1'b0);
            n_vec++;
            if (IN_READY !== 1'b1) begin
                n_err++;
                $display("FAIL bubble_ready[%0d]: got %b want 1", c, IN_READY);
            end
            model_edge();
            tick();
            n_vec++;
            if (STAGE_VALID !== sv_t[c] || STAGE_VALID !== m_v) begin
                n_err++;
                $display("FAIL bubble_sv[%0d]: got %b want %b", c, STAGE_VALID, sv_t[c]);
            end
            if (c >= 2) begin
                n_vec++;
                if (VALID_OUT !== 1'b1 || INSTR_OUT !== 11'h7FF) begin
                    n_err++;
                    $display("FAIL bubble_out[%0d]: got v=%b %h want 1 7ff", c, VALID_OUT, INSTR_OUT);
                end
            end
        end
    endtask

    task automatic test_full_hold();
        logic        dv_t [3];
        logic [10:0] di_t [3];
        for (int c = 0; c < 4; c++) begin
            apply(1'b1, 11'h123, 6'h3F, 1'b1, 1'b0, 1'b0);
            n_vec++;
            if (IN_READY !== 1'b0) begin
                n_err++;
                $display("FAIL full_ready[%0d]: got %b want 0", c, IN_READY);
            end
            model_edge();
            tick();
            n_vec++;
            if (STAGE_VALID !== 3'b111 || OCCUPANCY !== 2'd3 || INSTR_OUT !== 11'h7FF || COUNTER_OUT !== 6'd1) begin
                n_err++;
                $display("FAIL full_hold[%0d]: got sv=%b occ=%0d %h/%0d want 111 3 7ff/1",
                         c, STAGE_VALID, OCCUPANCY, INSTR_OUT, COUNTER_OUT);
            end
        end
        dv_t[0] = 1'b1; di_t[0] = 11'h6B5;
        dv_t[1] = 1'b1; di_t[1] = 11'h0AA;
        dv_t[2] = 1'b0; di_t[2] = 11'h0AA;
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 11'h0, 6'h0, 1'b0, 1'b0, 1'b0);
            model_edge();
            tick();
            n_vec++;
            if (VALID_OUT !== dv_t[c] || INSTR_OUT !== di_t[c]) begin
                n_err++;
                $display("FAIL full_drain[%0d]: got v=%b %h want %b %h", c, VALID_OUT, INSTR_OUT, dv_t[c], di_t[c]);
            end
        end
        n_vec++;
        if (OCCUPANCY !== 2'd0) begin
            n_err++;
            $display("FAIL full_drained_occ: got %0d want 0", OCCUPANCY);
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 3; c++) begin
            apply(1'b1, 11'h111 + 11'(c), 6'(c + 10), 1'b0, 1'b0, 1'b0);
            model_edge();
            tick();
        end
        apply(1'b1, 11'h222, 6'h22, 1'b1, 1'b1, 1'b0);
        model_edge();
        tick();
        n_vec++;
        if (STAGE_VALID !== 3'b000 || VALID_OUT !== 1'b0 || OCCUPANCY !== 2'd0) begin
            n_err++;
            $display("FAIL flush_clear: got sv=%b v=%b occ=%0d want 000 0 0", STAGE_VALID, VALID_OUT, OCCUPANCY);
        end
        n_vec++;
        if (INSTR_OUT !== 11'h111 || COUNTER_OUT !== 6'd10) begin
            n_err++;
            $display("FAIL flush_data_hold: got %h/%0d want 111/10", INSTR_OUT, COUNTER_OUT);
        end
        apply(1'b0, 11'h0, 6'h0, 1'b0, 1'b0, 1'b0);
        model_edge();
        tick();
        n_vec++;
        if (STAGE_VALID !== 3'b000) begin
            n_err++;
            $display("FAIL flush_input_dropped: got sv=%b want 000", STAGE_VALID);
        end
    endtask

    task automatic test_reset_priority();
        int lat;
        for (int c = 0; c < 2; c++) begin
            apply(1'b1, 11'h300 + 11'(c), 6'(c + 20), 1'b0, 1'b0, 1'b0);
            model_edge();
            tick();
        end
        apply(1'b1, 11'h333, 6'h33, 1'b1, 1'b1, 1'b1);
        model_edge();
        tick();
        n_vec++;
        if (VALID_OUT !== 1'b0 || INSTR_OUT !== 11'h0 || COUNTER_OUT !== 6'h0 ||
            STAGE_VALID !== 3'b000 || OCCUPANCY !== 2'd0 || IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL rstprio_out: got v=%b %h/%h sv=%b occ=%0d rdy=%b want all 0, rdy 1",
                     VALID_OUT, INSTR_OUT, COUNTER_OUT, STAGE_VALID, OCCUPANCY, IN_READY);
        end
        apply(1'b1, 11'h444, 6'h04, 1'b0, 1'b0, 1'b0);
        model_edge();
        tick();
        lat = 1;
        while (VALID_OUT !== 1'b1 && lat < 10) begin
            apply(1'b0, 11'h0, 6'h0, 1'b0, 1'b0, 1'b0);
            model_edge();
            tick();
            lat++;
        end
        n_vec++;
        if (lat != D || INSTR_OUT !== 11'h444 || COUNTER_OUT !== 6'h04) begin
            n_err++;
            $display("FAIL rstprio_latency: got %0d cycles %h/%h want %0d 444/04", lat, INSTR_OUT, COUNTER_OUT, D);
        end
        apply(1'b0, 11'h0, 6'h0, 1'b0, 1'b0, 1'b0);
        model_edge();
        tick();
    endtask

    task automatic test_random();
        logic        vin, st, fl, rs, pend, exp_rdy;
        logic [10:0] ins;
        logic [5:0]  pc;
        pend = 1'b0;
        vin = 1'b0; ins = '0; pc = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pend) begin
                vin = 1'($urandom_range(0, 1));
                ins = 11'($urandom);
                pc  = 6'($urandom);
            end
            st = ($urandom_range(0, 9) < 4);
            fl = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 59) == 0);
            apply(vin, ins, pc, st, fl, rs);
            exp_rdy = model_ready();
            n_vec++;
            if (IN_READY !== exp_rdy) begin
                n_err++;
                $display("FAIL rand_ready[%0d]: got %b want %b", c, IN_READY, exp_rdy);
            end
            // Upstream keeps offering a refused entry until it is taken.
            pend = vin && !exp_rdy && !fl && !rs;
            model_edge();
            tick();
            n_vec++;
            if (STAGE_VALID !== m_v || OCCUPANCY !== 2'($countones(m_v)) ||
                VALID_OUT !== m_v[D-1] || INSTR_OUT !== m_i[D-1] || COUNTER_OUT !== m_p[D-1]) begin
                n_err++;
                $display("FAIL rand_state[%0d]: got sv=%b occ=%0d %h/%h want sv=%b occ=%0d %h/%h",
                         c, STAGE_VALID, OCCUPANCY, INSTR_OUT, COUNTER_OUT,
                         m_v, $countones(m_v), m_i[D-1], m_p[D-1]);
            end
        end
    endtask

    task automatic test_sweep();
        int lat1, lat5, want_occ;
        logic [31:0] got1;
        logic [15:0] got5;
        lat1 = 0; lat5 = 0; got1 = '0; got5 = '0;
        apply_s(1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        tick();
        apply_s(1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (o1_valid !== 1'b0 || o5_valid !== 1'b0 || o1_ready !== 1'b1 || o5_ready !== 1'b1) begin
            n_err++;
            $display("FAIL sweep_reset: got v1=%b v5=%b r1=%b r5=%b want 0 0 1 1", o1_valid, o5_valid, o1_ready, o5_ready);
        end
        for (int e = 1; e <= 12; e++) begin
            if (e == 1) apply_s(1'b1, 32'hDEADBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b0);
            else        apply_s(1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0);
            tick();
            if (lat1 == 0 && o1_valid === 1'b1) begin lat1 = e; got1 = o1_instr; end
            if (lat5 == 0 && o5_valid === 1'b1) begin lat5 = e; got5 = o5_pc; end
        end
        n_vec++;
        if (lat1 != 1 || got1 !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL sweep_lat_d1: got %0d cycles %h want 1 deadbeef", lat1, got1);
        end
        n_vec++;
        if (lat5 != 5 || got5 !== 16'hBEEF) begin
            n_err++;
            $display("FAIL sweep_lat_d5: got %0d cycles %h want 5 beef", lat5, got5);
        end
        for (int c = 1; c <= 8; c++) begin
            apply_s(1'b1, 32'h12345678 + 32'(c), 16'(c), 1'b1, 1'b0, 1'b0);
            tick();
            want_occ = (c < 5) ? c : 5;
            n_vec++;
            if (o5_occ !== 3'(want_occ) || o1_occ !== 1'b1) begin
                n_err++;
                $display("FAIL sweep_occ[%0d]: got d5=%0d d1=%0d want %0d 1", c, o5_occ, o1_occ, want_occ);
            end
        end
        n_vec++;
        if (o1_ready !== 1'b0 || o5_ready !== 1'b0 || o1_sv !== 1'b1 || o5_sv !== 5'h1F) begin
            n_err++;
            $display("FAIL sweep_full: got r1=%b r5=%b sv1=%b sv5=%b want 0 0 1 11111", o1_ready, o5_ready, o1_sv, o5_sv);
        end
        n_vec++;
        if (o1_instr !== 32'h12345679 || o5_instr !== 32'h12345679) begin
            n_err++;
            $display("FAIL sweep_hold_head: got d1=%h d5=%h want 12345679", o1_instr, o5_instr);
        end
        apply_s(1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (o1_ready !== 1'b1 || o1_valid !== 1'b1) begin
            n_err++;
            $display("FAIL sweep_d1_ready: got r=%b v=%b want 1 1", o1_ready, o1_valid);
        end
        apply_s(1'b0, 32'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        tick();
        n_vec++;
        if (o1_occ !== 1'b0 || o5_occ !== 3'd0) begin
            n_err++;
            $display("FAIL sweep_flush: got d1=%0d d5=%0d want 0 0", o1_occ, o5_occ);
        end
    endtask

    initial begin
        m_v = '0;
        for (int k = 0; k < D; k++) begin
            m_i[k] = '0;
            m_p[k] = '0;
        end
        apply(1'b0, 11'h0, 6'h0, 1'b0, 1'b0, 1'b1);
        apply_s(1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        test_reset();
        test_stream();
        test_bubble();
        test_full_hold();
        test_flush();
        test_reset_priority();
        test_random();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_pipe_chain.md
Name: instr_pipe_chain

Overview:
- Parametrised successor to the single-stage instruction/PC pipeline register. Chains DEPTH stages internally instead of instantiating one module per stage.
- Each stage carries an instruction word, its program counter and a valid bit.
- Adds per-stage valid tracking, back-pressure stall with bubble squeezing, synchronous flush and an occupancy count.
- Sits between fetch and decode/execute. It replaces hand-chained stage instances in the datapath and benches.

Parameters:
- INSTR_W, 11, instruction word width in bits.
- PC_W, 6, program counter width in bits.
- DEPTH, 3, number of pipeline stages (>= 1).
- OCC_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- CLK  in  1  single clock; all state updates on its rising edge.
- RST  in  1  synchronous, active-high reset.
- VALID_IN  in  1  input entry valid.
- INSTR_IN  in  INSTR_W  input instruction.
- COUNTER_IN  in  PC_W  input program counter.
- IN_READY  out  1  stage 0 can accept this cycle (combinational).
- STALL  in  1  downstream cannot accept the output entry this cycle.
- FLUSH  in  1  invalidate all stages.
- VALID_OUT  out  1  valid bit of stage DEPTH-1.
- INSTR_OUT  out  INSTR_W  instruction of stage DEPTH-1.
- COUNTER_OUT  out  PC_W  PC of stage DEPTH-1.
- STAGE_VALID  out  DEPTH  valid bit of every stage; bit k is stage k, stage 0 is input-facing.
- OCCUPANCY  out  OCC_W  number of valid stages (registered).

Behaviour:
- Reset: when RST=1 at an edge, all valid bits, instruction fields, PC fields and OCCUPANCY become 0. After reset, VALID_OUT=0, INSTR_OUT=0, COUNTER_OUT=0 and IN_READY=1. RST overrides FLUSH and STALL.
- Ready chain (combinational):
  - ready[DEPTH] = !STALL.
  - ready[k] = !valid[k] || ready[k+1].
  - IN_READY = ready[0].
- Advance: on each edge with no RST/FLUSH, every stage k with ready[k]=1 loads from its source. The source is stage k-1, or the input ports when k=0.
  - valid[k] takes the source valid (VALID_IN for k=0).
  - Data fields load only when the source is valid; otherwise they hold their previous value.
  - Stages with ready[k]=0 hold valid and data.
- Bubble squeezing: an invalid stage always accepts, even under STALL. Entries upstream of a bubble keep moving until they pack against the stalled output.
- Entry order is strictly preserved; no entry is ever duplicated or lost except by FLUSH.
- Latency: with STALL=0, an entry presented at edge n appears on the outputs after edge n+DEPTH-1. It is first valid at the output stage DEPTH cycles after it is driven. Throughput is one entry per cycle.
- Input accept: an entry is taken only when VALID_IN && IN_READY. When IN_READY=0 the upstream must hold its entry; the block ignores VALID_IN.
- Full: all DEPTH stages valid and STALL=1 gives IN_READY=0, and everything holds.
- FLUSH=1 (no RST):
  - All valid bits clear at the edge.
  - The input entry is dropped, even if VALID_IN=1.
  - Data fields hold.
  - OCCUPANCY becomes 0.
  - FLUSH dominates STALL.
- OCCUPANCY: updated every edge as the popcount of the next-state valid bits. It never exceeds DEPTH and never wraps.
- DEPTH=1: the block is a single register with valid. IN_READY = !VALID_OUT || !STALL.
- Reset mid-stream: in-flight entries are discarded with no partial outputs. Accepting resumes on the first edge after RST deasserts.

Test Plan:
- DEPTH=3, STALL=0: feed 11'h7FF/pc 1, 11'h000/pc 2, 11'h6B5/pc 3 on consecutive cycles. Outputs show 7FF/1, 000/2, 6B5/3 with VALID_OUT=1 on the 3rd, 4th and 5th edges. OCCUPANCY ramps 1,2,3 and then falls to 0 after the input stops.
- Stall with bubble: preload stage 2 with 7FF and hold stage 1 empty, then send 6B5 with STALL=1. 6B5 advances to stage 1, IN_READY stays 1 and the output stays 7FF. Filling stage 0 then gives IN_READY=0.
- Full hold: fill all 3 stages and hold STALL=1 for 4 cycles with VALID_IN=1 and 11'h123. Outputs, STAGE_VALID=3'b111 and OCCUPANCY=3 stay constant, and 123 is not accepted. Releasing STALL drains the stages in order.
- Flush: 3 stages valid, STALL=1, FLUSH=1, VALID_IN=1. Next edge gives STAGE_VALID=0, VALID_OUT=0, OCCUPANCY=0, and the input is not captured.
- Reset priority: stream running, assert RST with FLUSH=1 and STALL=1. Next edge gives all outputs 0 and IN_READY=1. The first entry after deassert emerges DEPTH cycles later.
- Parameter sweep: DEPTH=1 and DEPTH=5 with INSTR_W=32 and PC_W=16. Latency equals DEPTH and the occupancy saturates at DEPTH.
